// File: rtl/div_unit_pkg.sv
// Shared CPU datapath conventions: FSM state encoding and default operand width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_ZERO = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
// Latency: n/a (wiring only).
// Backpressure: none; start is a pulse, completion is signalled by done.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );

endinterface

// File: rtl/div_unit.sv
// Signed restoring divider (MIPS DIV semantics): quotient to LO, remainder to HI.
// Latency: done pulses WIDTH+1 cycles after start is sampled; divide-by-zero pulses after 1.
// Backpressure: start is ignored while busy; operands are captured only at the accepting edge.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    div_unit_if.slave  bus
);

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic             w_load;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;          // quotient shift register, holds |dividend| initially
    logic [WIDTH-1:0] r_rem;        // partial remainder, always < |divisor|
    logic [WIDTH:0]   r_dvsr;       // |divisor|, one extra bit so 2^(WIDTH-1) fits
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic             w_last;

    // |dividend| read as unsigned: the most negative value negates to itself, which is 2^(WIDTH-1).
    assign w_a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_b_ext = {bus.divisor[WIDTH-1], bus.divisor};
    assign w_b_mag = w_b_ext[WIDTH] ? -w_b_ext : w_b_ext;

    // Trial subtraction. Because r_rem < r_dvsr, a successful trial result is < r_dvsr
    // and therefore fits exactly in the low WIDTH bits of the modular difference.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= r_dvsr);
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvsr[WIDTH-1:0];
    assign w_last  = (r_cnt == LAST_ITER);

    // Next-state and operand-load decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        w_state_nxt = ST_ZERO;
                    end else begin
                        w_state_nxt = ST_CALC;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            ST_ZERO: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, one quotient bit per CALC cycle, sign fix-up and result hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_q      <= w_a_mag;
                        r_rem    <= '0;
                        r_dvsr   <= w_b_mag;
                        r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_sign_r <= bus.dividend[WIDTH-1];
                        r_cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_cnt <= r_cnt + CNT_ONE;
                end
                ST_FIX: begin
                    // Negating 2^(WIDTH-1) wraps to itself, giving the MIPS overflow result.
                    r_quotient  <= r_sign_q ? -r_q   : r_q;
                    r_remainder <= r_sign_r ? -r_rem : r_rem;
                    r_done      <= 1'b1;
                end
                ST_ZERO: begin
                    r_done     <= 1'b1;
                    r_div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences, random ops.
// Latency: checks done at 33 cycles (1 for divide-by-zero) after start is accepted.
// Backpressure: exercises start-while-busy, back-to-back starts and mid-operation reset.
module tb_div_unit;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_q   = 32'd0;    // model of the held LO result
    logic [31:0] m_r   = 32'd0;    // model of the held HI result

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic, truncating toward zero, remainder follows dividend.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q  = m_q;
            r  = m_r;
            dz = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
        end
    endtask

    // Must be entered at a negedge; returns at the negedge where done is seen (or after a timeout).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic bz, output int lat, output logic busy_ok);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock);
        @(negedge clock);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        busy_ok      = (bus.busy === 1'b1);
        lat          = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.done === 1'b1) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == inj) begin
                bus.start    = 1'b1;
                bus.dividend = ia;
                bus.divisor  = ib;
            end else begin
                bus.start    = 1'b0;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
        end
        bus.start = 1'b0;
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_zero;
        bz = bus.busy;
    endtask

    task automatic op_check(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er, input logic edz,
                            input int inj, input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        bz;
        int          lat;
        logic        busy_ok;
        do_op(a, b, inj, ia, ib, q, r, dz, bz, lat, busy_ok);
        chk({nm, ".quotient"},  q, eq);
        chk({nm, ".remainder"}, r, er);
        chk({nm, ".div_zero"},  {31'd0, dz}, {31'd0, edz});
        chk({nm, ".latency"},   32'(lat), edz ? 32'd1 : 32'd33);
        chk({nm, ".busy_held"}, {31'd0, busy_ok}, 32'd1);
        chk({nm, ".busy_at_done"}, {31'd0, bz}, 32'd0);
        if (!edz) begin
            m_q = eq;
            m_r = er;
        end
    endtask

    task automatic gap_check(input string nm);
        @(negedge clock);
        chk({nm, ".done_one_cycle"},     {31'd0, bus.done},     32'd0);
        chk({nm, ".div_zero_one_cycle"}, {31'd0, bus.div_zero}, 32'd0);
    endtask

    task automatic outputs_zero(input string nm);
        chk({nm, ".quotient"},  bus.quotient,  32'd0);
        chk({nm, ".remainder"}, bus.remainder, 32'd0);
        chk({nm, ".busy"},      {31'd0, bus.busy},     32'd0);
        chk({nm, ".done"},      {31'd0, bus.done},     32'd0);
        chk({nm, ".div_zero"},  {31'd0, bus.div_zero}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          seen;

        tbl[0]  = '{a: 32'd7,          b: 32'd2,          q: 32'd3,          r: 32'd1,          dz: 1'b0};
        tbl[1]  = '{a: 32'd7,          b: 32'd0,          q: 32'd3,          r: 32'd1,          dz: 1'b1};
        tbl[2]  = '{a: 32'hFFFFFFF9,   b: 32'd2,          q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   dz: 1'b0};
        tbl[3]  = '{a: 32'd7,          b: 32'hFFFFFFFE,   q: 32'hFFFFFFFD,   r: 32'd1,          dz: 1'b0};
        tbl[4]  = '{a: 32'hFFFFFFF9,   b: 32'hFFFFFFFE,   q: 32'd3,          r: 32'hFFFFFFFF,   dz: 1'b0};
        tbl[5]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   q: 32'h80000000,   r: 32'd0,          dz: 1'b0};
        tbl[6]  = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          dz: 1'b0};
        tbl[7]  = '{a: 32'd1,          b: 32'h80000000,   q: 32'd0,          r: 32'd1,          dz: 1'b0};
        tbl[8]  = '{a: 32'h80000000,   b: 32'd2,          q: 32'hC0000000,   r: 32'd0,          dz: 1'b0};
        tbl[9]  = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   q: 32'd0,          r: 32'h7FFFFFFF,   dz: 1'b0};
        tbl[10] = '{a: 32'h80000000,   b: 32'h80000000,   q: 32'd1,          r: 32'd0,          dz: 1'b0};
        tbl[11] = '{a: 32'hFFFFFFFF,   b: 32'd0,          q: 32'd1,          r: 32'd0,          dz: 1'b1};
        tbl[12] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dz: 1'b0};
        tbl[13] = '{a: 32'hFFFFFF9C,   b: 32'd7,          q: 32'hFFFFFFF2,   r: 32'hFFFFFFFE,   dz: 1'b0};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;

        // Reset state
        repeat (2) @(negedge clock);
        outputs_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            op_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz,
                     0, 32'd0, 32'd0);
            gap_check($sformatf("vec%0d", i));
        end

        // Back-to-back: second start in the same cycle as the first done
        op_check("b2b_first", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 32'd0, 32'd0);
        op_check("b2b_second", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 0, 32'd0, 32'd0);
        gap_check("b2b");

        // Start pulsed while busy must be ignored
        op_check("ignore_busy_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, 32'd5, 32'd1);
        gap_check("ignore_busy_start");

        // Reset mid-operation: outputs clear immediately and no done follows
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        outputs_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        m_q   = 32'd0;
        m_r   = 32'd0;
        seen  = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen++;
        end
        chk("mid_reset.no_done", 32'(seen), 32'd0);
        op_check("after_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, 32'd0, 32'd0);
        gap_check("after_reset");

        // Randomized operations against the arithmetic reference
        for (int k = 0; k < 150; k++) begin
            a = (k % 5 == 0) ? 32'h80000000 : 32'($urandom);
            case (k % 6)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'd0 - 32'($urandom_range(1, 20));
                3:       b = 32'hFFFFFFFF;
                default: b = 32'($urandom);
            endcase
            ref_div(a, b, eq, er, edz);
            op_check($sformatf("rand%0d", k), a, b, eq, er, edz, 0, 32'd0, 32'd0);
            gap_check($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
